// File: rtl/vector_read_module.sv
// Memory-to-register load engine: issues sequential reads from a synchronous
// data memory and assembles the returned words into a vector or a scalar.
module vector_read_module #(
    parameter int unsigned I = 20,
    parameter int unsigned L = 32,
    parameter int unsigned A = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op_type,
    input  logic [A-1:0]        base_address,
    input  logic [L-1:0]        read_data,
    output logic [A-1:0]        read_address,
    output logic                read_en,
    output logic [I-1:0][L-1:0] vector_data,
    output logic [L-1:0]        scalar_data,
    output logic                busy,
    output logic                finished
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [A-1:0] LAST_VEC = A'(I - 1);

    state_t       state_q, state_d;
    logic         op_q;
    logic [A-1:0] base_q;
    logic [A-1:0] count_q;
    logic [A-1:0] last_idx;
    logic         cap_valid_q;
    logic [A-1:0] cap_idx_q;

    assign last_idx = op_q ? LAST_VEC : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and control outputs are decoded from state so reset clears them at once.
    always_comb begin
        state_d      = state_q;
        read_en      = 1'b0;
        read_address = '0;
        busy         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                read_en      = 1'b1;
                read_address = base_q + count_q;
                busy         = 1'b1;
                if (count_q == last_idx) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
        end else if (state_q == IDLE && start) begin
            op_q    <= op_type;
            base_q  <= base_address;
            count_q <= '0;
        end else if (state_q == ISSUE) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Returned word lines up with the address issued one cycle earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            vector_data <= '0;
            scalar_data <= '0;
            finished    <= 1'b0;
        end else begin
            cap_valid_q <= read_en;
            cap_idx_q   <= count_q;
            finished    <= (state_q == DRAIN);
            if (cap_valid_q) begin
                if (op_q) begin
                    for (int unsigned k = 0; k < I; k++) begin
                        if (cap_idx_q == A'(k)) vector_data[k] <= read_data;
                    end
                end else begin
                    scalar_data <= read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_read_module.sv
// Randomized self-checking bench for vector_read_module against a memory image
// and a per-load expectation of address sequence, handshake timing and results.
module tb_vector_read_module;

    localparam int unsigned I = 20;
    localparam int unsigned L = 32;
    localparam int unsigned A = 10;
    localparam int unsigned DEPTH = 1 << A;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                op_type = 1'b0;
    logic [A-1:0]        base_address = '0;
    logic [L-1:0]        read_data;
    logic [A-1:0]        read_address;
    logic                read_en;
    logic [I-1:0][L-1:0] vector_data;
    logic [L-1:0]        scalar_data;
    logic                busy;
    logic                finished;

    logic [L-1:0] mem [DEPTH];
    logic [L-1:0] exp_vec [I];
    logic [L-1:0] exp_scalar;

    int checks = 0;
    int errors = 0;

    vector_read_module #(.I(I), .L(L), .A(A)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_type      (op_type),
        .base_address (base_address),
        .read_data    (read_data),
        .read_address (read_address),
        .read_en      (read_en),
        .vector_data  (vector_data),
        .scalar_data  (scalar_data),
        .busy         (busy),
        .finished     (finished)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: address in cycle t gives data in cycle t+1.
    always @(posedge clk) begin
        if (read_en) read_data <= mem[read_address];
        else         read_data <= $urandom;
    end

    task automatic check_results(input string name);
        for (int k = 0; k < int'(I); k++) begin
            checks++;
            if (vector_data[k] !== exp_vec[k]) begin
                errors++;
                $display("FAIL %s vector item %0d got %h expected %h", name, k, vector_data[k], exp_vec[k]);
            end
        end
        checks++;
        if (scalar_data !== exp_scalar) begin
            errors++;
            $display("FAIL %s scalar got %h expected %h", name, scalar_data, exp_scalar);
        end
    endtask

    // Runs one load from cycle T0 to its finished cycle, returning at that
    // cycle's negedge. pre_started: start was already raised in the previous
    // finished cycle. pulse_at: cycle of a spurious start (0 = none).
    task automatic run_load(input string name, input logic op, input logic [A-1:0] base,
                            input int pulse_at, input bit pre_started);
        int n;
        logic [A+2:0] got, want;
        logic [A-1:0] a;
        n = op ? int'(I) : 1;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1; op_type = op; base_address = base;
        end
        for (int t = 1; t <= n + 2; t++) begin
            @(negedge clk);
            a = base + A'(t - 1);
            want = {(t <= n), ((t <= n) ? a : {A{1'b0}}), (t <= n + 1), (t == n + 2)};
            got  = {read_en, read_address, busy, finished};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s T%0d {en,addr,busy,fin} got %b_%h_%b_%b expected %b_%h_%b_%b",
                         name, t, got[A+2], got[A+1:2], got[1], got[0],
                         want[A+2], want[A+1:2], want[1], want[0]);
            end
            start = 1'b0;
            if (t == pulse_at) begin
                start = 1'b1; op_type = ~op; base_address = $urandom;
            end
        end
        if (op) begin
            for (int k = 0; k < int'(I); k++) exp_vec[k] = mem[(int'(base) + k) % DEPTH];
        end else begin
            exp_scalar = mem[base];
        end
        check_results(name);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({read_en, read_address, busy, finished} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {read_en, read_address, busy, finished});
        end
        for (int k = 0; k < int'(I); k++) exp_vec[k] = '0;
        exp_scalar = '0;
        check_results("reset");
    endtask

    task automatic test_vector_plan;
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = L'(a * 3);
        run_load("vector_010", 1'b1, A'(10'h010), 0, 1'b0);
    endtask

    task automatic test_scalar_plan;
        mem[10'h3FF] = 32'hDEADBEEF;
        run_load("scalar_3ff", 1'b0, A'(10'h3FF), 0, 1'b0);
    endtask

    task automatic test_wrap;
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = $urandom;
        run_load("wrap_3f8", 1'b1, A'(10'h3F8), 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_load("ignored_start", 1'b1, A'($urandom), 5, 1'b0);
        start = 1'b1; op_type = 1'b1; base_address = A'($urandom);
        run_load("b2b_vector", 1'b1, base_address, 0, 1'b1);
        start = 1'b1; op_type = 1'b0; base_address = A'($urandom);
        run_load("b2b_scalar", 1'b0, base_address, 0, 1'b1);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        start = 1'b1; op_type = 1'b1; base_address = A'($urandom);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({read_en, read_address, busy, finished} !== '0 || vector_data !== '0) begin
            errors++;
            $display("FAIL async_reset outputs got en=%b addr=%h busy=%b fin=%b vec_nonzero=%b expected 0",
                     read_en, read_address, busy, finished, (vector_data !== '0));
        end
        for (int k = 0; k < int'(I); k++) exp_vec[k] = '0;
        exp_scalar = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (finished !== 1'b0) begin
                errors++;
                $display("FAIL async_reset finished got %b expected 0", finished);
            end
        end
        rst = 1'b0;
        check_results("after_reset");
        run_load("post_reset_scalar", 1'b0, A'($urandom), 0, 1'b0);
    endtask

    task automatic test_random_loads;
        for (int r = 0; r < 12; r++) begin
            for (int j = 0; j < 16; j++) mem[$urandom_range(DEPTH - 1)] = $urandom;
            run_load("random", 1'($urandom), A'($urandom), (r % 3 == 0) ? 2 : 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_vector_plan();
        test_scalar_plan();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random_loads();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
